// File: rtl/btb_bht_predictor.sv
// rtl/btb_bht_predictor.sv - direct-mapped BTB with 2-bit BHT counters for fetch-side next-PC prediction
//
// Optional feature macro: BP_STATS_EN (adds stat_upd_cnt / stat_correct_cnt outputs)
//
// Ports:
//   clk               clock
//   resetn            synchronous active-low reset
//   lk_pc             fetch PC being looked up (combinational)
//   lk_hit            tag hit and counter predicts taken
//   lk_target         {stored_target, 2'b00} on hit, lk_pc + 4 otherwise
//   upd_valid         training request from ID
//   upd_pc            PC of the resolved branch
//   upd_taken         resolved direction
//   upd_target        resolved target, bits [1:0] ignored
//   bp_flush          invalidate all entries on the next edge
//   stat_upd_cnt      (BP_STATS_EN) accepted update count
//   stat_correct_cnt  (BP_STATS_EN) accepted updates whose prior prediction was right

module btb_bht_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lk_pc,
    output logic        lk_hit,
    output logic [31:0] lk_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        bp_flush
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_upd_cnt,
    output logic [31:0] stat_correct_cnt
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_W + IDX_W + 1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Lookup side: pure read of the current table, no bypass from a same-cycle update
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_match;

    assign lk_idx    = lk_pc[IDX_W+1:2];
    assign lk_tag    = lk_pc[TAG_HI:TAG_LO];
    assign lk_match  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_hit    = lk_match && ctr_q[lk_idx][1];
    assign lk_target = lk_hit ? {target_q[lk_idx], 2'b00} : lk_pc + 32'd4;

    // Update side
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;
    logic [1:0]       ctr_next;

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[TAG_HI:TAG_LO];
    assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        ctr_next = ctr_q[upd_idx];
        if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'd1;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bp_flush) begin
            // Only the valid bits are cleared; the same-cycle update is dropped
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_match) begin
                ctr_q[upd_idx] <= ctr_next;
                if (upd_taken) target_q[upd_idx] <= upd_target[31:2];
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target[31:2];
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic upd_pred;
    assign upd_pred = upd_match && ctr_q[upd_idx][1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_upd_cnt     <= '0;
            stat_correct_cnt <= '0;
        end else if (upd_valid && !bp_flush) begin
            stat_upd_cnt <= stat_upd_cnt + 32'd1;
            if (upd_pred == upd_taken) stat_correct_cnt <= stat_correct_cnt + 32'd1;
        end
    end
`endif

    // Address bits outside the index/tag fields do not participate in the table
    logic unused_bits;
    assign unused_bits = ^{upd_pc[31:TAG_HI+1], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: tb/tb_btb_bht_predictor.sv
// tb/tb_btb_bht_predictor.sv - scoreboard testbench for btb_bht_predictor against a behavioural table model

module tb_btb_bht_predictor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic [31:0] lk_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        bp_flush;
`ifdef BP_STATS_EN
    logic [31:0] stat_upd_cnt;
    logic [31:0] stat_correct_cnt;
`endif

    always #5 clk = ~clk;

    btb_bht_predictor #(.ENTRIES(16), .TAG_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lk_pc      (lk_pc),
        .lk_hit     (lk_hit),
        .lk_target  (lk_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .bp_flush   (bp_flush)
`ifdef BP_STATS_EN
        ,
        .stat_upd_cnt     (stat_upd_cnt),
        .stat_correct_cnt (stat_correct_cnt)
`endif
    );

    // Behavioural model: 16 entries, index = word address mod 16, tag = (pc / 64) mod 256
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_upd;
    int unsigned m_corr;
    bit          prev_rn = 1'b1;

    typedef struct {
        logic        hit;
        logic [31:0] target;
        logic [31:0] upd_cnt;
        logic [31:0] corr_cnt;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / 64) % 256;
    endfunction

    function automatic bit model_predict(input logic [31:0] pc);
        int unsigned i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_step(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg, input logic fl, input logic rn);
        int unsigned i;
        i = idx_of(upc);
        if (!rn) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
                m_tgt[k]   = 0;
            end
            m_upd  = 0;
            m_corr = 0;
        end else if (fl) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (uv) begin
            m_upd = m_upd + 1;
            if (model_predict(upc) == ut) m_corr = m_corr + 1;
            if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
                m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (ut) m_tgt[i] = utg & 32'hffff_fffc;
            end else if (ut) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(upc);
                m_tgt[i]   = utg & 32'hffff_fffc;
                m_ctr[i]   = 2;
            end
        end
    endtask

    // One clock cycle: drive, record the expected lookup response from pre-edge state, advance model
    task automatic cycle(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg, input logic fl,
                         input logic rn, input string nm);
        exp_t e;
        lk_pc      = lk;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        bp_flush   = fl;
        resetn     = rn;
        // The first cycle of a reset assertion still shows the old table; compare once it is cleared
        if (rn || !prev_rn) begin
            e.hit      = model_predict(lk);
            e.target   = e.hit ? m_tgt[idx_of(lk)] : lk + 32'd4;
            e.upd_cnt  = m_upd;
            e.corr_cnt = m_corr;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        model_step(uv, upc, ut, utg, fl, rn);
        prev_rn = rn;
        #1;
    endtask

    task automatic look(input logic [31:0] lk, input string nm);
        cycle(lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, nm);
    endtask

    task automatic train(input logic [31:0] pc, input logic ut, input logic [31:0] tg, input string nm);
        cycle(pc, 1'b1, pc, ut, tg, 1'b0, 1'b1, nm);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++)
            cycle(32'h1c00_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "reset");
    endtask

    // Monitor: the lookup output is always present; compare whenever an expectation is pending
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks = checks + 1;
            if (lk_hit !== e.hit) begin
                errors = errors + 1;
                $display("FAIL %s lk_hit pc=%h got %b expected %b", nm, lk_pc, lk_hit, e.hit);
            end
            checks = checks + 1;
            if (lk_target !== e.target) begin
                errors = errors + 1;
                $display("FAIL %s lk_target pc=%h got %h expected %h", nm, lk_pc, lk_target, e.target);
            end
`ifdef BP_STATS_EN
            checks = checks + 1;
            if (stat_upd_cnt !== e.upd_cnt) begin
                errors = errors + 1;
                $display("FAIL %s stat_upd_cnt got %0d expected %0d", nm, stat_upd_cnt, e.upd_cnt);
            end
            checks = checks + 1;
            if (stat_correct_cnt !== e.corr_cnt) begin
                errors = errors + 1;
                $display("FAIL %s stat_correct_cnt got %0d expected %0d", nm, stat_correct_cnt, e.corr_cnt);
            end
`endif
        end
    end

    localparam logic [31:0] PA = 32'h1c00_0010;
    localparam logic [31:0] PB = 32'h1c00_0410;
    localparam logic [31:0] PC = 32'h1c00_0020;

    initial begin
        logic [31:0] pool [8];
        logic [31:0] lk, upc, utg;
        logic        uv, ut, fl, rn;

        lk_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; bp_flush = 0; resetn = 0;

        do_reset(2);
        look(PA, "reset_lookup");
        train(PA, 1'b1, 32'h1c00_0100, "same_cycle_update");
        look(PA, "after_alloc");
        for (int k = 0; k < 3; k++) train(PA, 1'b1, 32'h1c00_0100, "taken_sat");
        look(PA, "ctr3");
        for (int k = 0; k < 2; k++) train(PA, 1'b0, 32'h0, "not_taken");
        look(PA, "ctr1_miss");
        for (int k = 0; k < 2; k++) train(PA, 1'b0, 32'h0, "floor");
        train(PA, 1'b1, 32'h1c00_0100, "from_zero");
        look(PA, "ctr1_after_floor");
        train(PA, 1'b1, 32'h1c00_0104, "back_to_2");
        look(PA, "retarget_hit");
        look(PB, "alias_miss");
        train(PB, 1'b1, 32'h1c00_0800, "alias_alloc");
        look(PA, "evicted");
        look(PB, "alias_hit");
        train(PC, 1'b0, 32'h1c00_0900, "nt_no_alloc");
        look(PC, "nt_still_miss");
        look(PB, "alias_intact");

        train(PA, 1'b1, 32'h1c00_0100, "pre_flush");
        cycle(PA, 1'b1, PC, 1'b1, 32'h1c00_0300, 1'b1, 1'b1, "flush_with_upd");
        look(PA, "flushed_a");
        look(PC, "flushed_c");
        train(PA, 1'b1, 32'h1c00_0100, "retrain");
        look(PA, "retrain_hit");
        train(PA, 1'b0, 32'h0, "retrain_dec");
        look(PA, "restart_at_2");

        do_reset(2);
        train(PA, 1'b1, 32'h1c00_0100, "stat_miss_t");
        train(PA, 1'b1, 32'h1c00_0100, "stat_hit_t");
        train(PA, 1'b1, 32'h1c00_0100, "stat_hit_t2");
        train(PA, 1'b0, 32'h0, "stat_hit_nt");
        train(PC, 1'b0, 32'h0, "stat_miss_nt");
        look(PA, "stat_5_3");
        cycle(PA, 1'b1, PA, 1'b1, 32'h1c00_0100, 1'b1, 1'b1, "stat_flush");
        look(PA, "stat_after_flush");

        look(32'hffff_fffc, "wrap");

        for (int k = 0; k < 8; k++)
            pool[k] = 32'h1c00_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 2)) << 6);
        pool[7] = 32'hffff_fffc;
        for (int n = 0; n < 600; n++) begin
            lk  = pool[$urandom_range(0, 7)];
            upc = pool[$urandom_range(0, 7)];
            utg = $urandom;
            uv  = ($urandom_range(0, 9) < 7);
            ut  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            rn  = ($urandom_range(0, 99) != 0);
            cycle(lk, uv, upc, ut, utg, fl, rn, "random");
        end

        do_reset(2);
        look(PA, "final_reset");

        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
